// File: rtl/vga_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rx_monitor
//  Description : Receive-side checker for a 640x480@60 VGA pattern source.
//                Measures line period, hsync width and lines per frame. Tracks
//                sync health with a lock state machine and signs every frame
//                with a CRC-16-CCITT over the visible 6-bit RGB symbols.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_rx_monitor #(
    parameter int H_TOTAL_EXP = 800,
    parameter int H_SYNC_EXP  = 96,
    parameter int V_TOTAL_EXP = 525,
    parameter int H_VIS_OFS   = 143,
    parameter int H_VISIBLE   = 640,
    parameter int V_VIS_OFS   = 35,
    parameter int V_VISIBLE   = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  vga_in,
    input  logic        err_clr,
    output logic        locked,
    output logic        frame_done,
    output logic        err,
    output logic [15:0] crc,
    output logic [9:0]  h_total_meas,
    output logic [6:0]  h_sync_meas,
    output logic [9:0]  v_total_meas
);

    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL_EXP);
    localparam logic [6:0]  H_SYNC_W  = 7'(H_SYNC_EXP);
    localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL_EXP);
    localparam logic [10:0] H_VIS_LO  = 11'(H_VIS_OFS);
    localparam logic [10:0] H_VIS_HI  = 11'(H_VIS_OFS + H_VISIBLE);
    localparam logic [10:0] V_VIS_LO  = 11'(V_VIS_OFS);
    localparam logic [10:0] V_VIS_HI  = 11'(V_VIS_OFS + V_VISIBLE);
    localparam logic [2:0]  LOCK_W    = 3'(LOCK_FRAMES);
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [9:0]  HCOUNT_MAX = 10'd1023;
    localparam logic [6:0]  HLOW_MAX   = 7'd127;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Six CCITT shift steps, symbol MSB first.
    function automatic logic [15:0] crc16_step6(input logic [15:0] c_in,
                                                input logic [5:0]  d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 5; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    // Input sampling and previous sync levels
    logic [7:0]  s;
    logic        hs_d;
    logic        vs_d;
    logic        hs_fall;
    logic        hs_rise;
    logic        vs_fall;

    // Measurement counters
    logic [9:0]  hcount;
    logic [10:0] hcount_inc;
    logic [6:0]  hlow;
    logic [9:0]  vlines;
    logic        bad;
    logic        line_bad;
    logic        sync_bad;
    logic        frame_bad;
    logic        watchdog;

    // Pixel signature
    logic        visible;
    logic [5:0]  sym;
    logic [15:0] crc_run;
    logic [15:0] crc_next;

    // Lock state machine
    state_t      state;
    state_t      state_next;
    logic [2:0]  good_cnt;
    logic [2:0]  good_cnt_next;
    logic [2:0]  good_cnt_inc;
    logic        err_set;
    logic        publish;

    assign hs_fall  = hs_d & ~s[7];
    assign hs_rise  = ~hs_d & s[7];
    assign vs_fall  = vs_d & ~s[3];

    assign hcount_inc = {1'b0, hcount} + 11'd1;
    assign line_bad   = hs_fall && (hcount_inc != H_TOTAL_W);
    assign sync_bad   = hs_rise && (hlow != H_SYNC_W);
    // Events landing on the vs_fall cycle still belong to the frame being closed.
    assign frame_bad  = bad || line_bad || sync_bad || (vlines != V_TOTAL_W);
    assign watchdog   = (hcount == HCOUNT_MAX);

    assign visible  = ({1'b0, hcount} >= H_VIS_LO) && ({1'b0, hcount} < H_VIS_HI) &&
                      ({1'b0, vlines} >= V_VIS_LO) && ({1'b0, vlines} < V_VIS_HI);
    assign sym      = {s[0], s[4], s[1], s[5], s[2], s[6]};
    assign crc_next = crc16_step6(crc_run, sym);

    assign good_cnt_inc = good_cnt + 3'd1;
    assign publish      = vs_fall && (state != IDLE);
    assign locked       = (state == LOCKED);

    // Lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            good_cnt <= 3'd0;
        end else if (!ena) begin
            state    <= IDLE;
            good_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
        end
    end

    // Lock next-state: watchdog overrides frame verdicts
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        err_set       = 1'b0;
        if (watchdog) begin
            state_next    = IDLE;
            good_cnt_next = 3'd0;
            err_set       = (state == LOCKED);
        end else if (vs_fall) begin
            case (state)
                IDLE: begin
                    state_next    = ACQ;
                    good_cnt_next = 3'd0;
                end
                ACQ: begin
                    if (frame_bad) begin
                        good_cnt_next = 3'd0;
                    end else begin
                        good_cnt_next = good_cnt_inc;
                        if (good_cnt_inc == LOCK_W) begin
                            state_next = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (frame_bad) begin
                        state_next    = ACQ;
                        good_cnt_next = 3'd0;
                        err_set       = 1'b1;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    good_cnt_next = 3'd0;
                end
            endcase
        end
    end

    // Pin sampling, timing measurement, running CRC and published results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s            <= 8'hFF;
            hs_d         <= 1'b1;
            vs_d         <= 1'b1;
            hcount       <= 10'd0;
            hlow         <= 7'd0;
            vlines       <= 10'd0;
            bad          <= 1'b0;
            crc_run      <= CRC_INIT;
            crc          <= 16'd0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
            h_total_meas <= 10'd0;
            h_sync_meas  <= 7'd0;
            v_total_meas <= 10'd0;
        end else if (!ena) begin
            s            <= 8'hFF;
            hs_d         <= 1'b1;
            vs_d         <= 1'b1;
            hcount       <= 10'd0;
            hlow         <= 7'd0;
            vlines       <= 10'd0;
            bad          <= 1'b0;
            crc_run      <= CRC_INIT;
            crc          <= 16'd0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
            h_total_meas <= 10'd0;
            h_sync_meas  <= 7'd0;
            v_total_meas <= 10'd0;
        end else begin
            s    <= vga_in;
            hs_d <= s[7];
            vs_d <= s[3];

            if (hs_fall) begin
                h_total_meas <= hcount_inc[9:0];
                hcount       <= 10'd0;
            end else if (hcount != HCOUNT_MAX) begin
                hcount <= hcount + 10'd1;
            end

            if (hs_rise) begin
                h_sync_meas <= hlow;
                hlow        <= 7'd0;
            end else if (!s[7] && (hlow != HLOW_MAX)) begin
                hlow <= hlow + 7'd1;
            end

            if (vs_fall) begin
                v_total_meas <= vlines;
                vlines       <= hs_fall ? 10'd1 : 10'd0;
            end else if (hs_fall) begin
                vlines <= vlines + 10'd1;
            end

            if (vs_fall) begin
                bad <= 1'b0;
            end else if (line_bad || sync_bad) begin
                bad <= 1'b1;
            end

            if (vs_fall) begin
                crc_run <= CRC_INIT;
            end else if (visible) begin
                crc_run <= crc_next;
            end

            frame_done <= publish;
            if (publish) begin
                crc <= crc_run;
            end

            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_rx_monitor
//  Description : Directed bench for vga_rx_monitor on a shrunken raster
//                (40 clocks x 12 lines, 24x8 visible). A frame table drives
//                whole frames and lists the expected verdict at each frame's
//                leading vsync fall; hand sequences cover watchdog and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_rx_monitor;

    localparam int HT     = 40;
    localparam int HS     = 6;
    localparam int VT     = 12;
    localparam int HVO    = 9;
    localparam int HV     = 24;
    localparam int VVO    = 2;
    localparam int VV     = 8;
    localparam int LF     = 2;
    localparam int VS_POS = 20;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  vga_in;
    logic        err_clr;
    logic        locked;
    logic        frame_done;
    logic        err;
    logic [15:0] crc;
    logic [9:0]  h_total_meas;
    logic [6:0]  h_sync_meas;
    logic [9:0]  v_total_meas;

    vga_rx_monitor #(
        .H_TOTAL_EXP(HT), .H_SYNC_EXP(HS), .V_TOTAL_EXP(VT),
        .H_VIS_OFS(HVO), .H_VISIBLE(HV), .V_VIS_OFS(VVO), .V_VISIBLE(VV),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .vga_in(vga_in), .err_clr(err_clr),
        .locked(locked), .frame_done(frame_done), .err(err), .crc(crc),
        .h_total_meas(h_total_meas), .h_sync_meas(h_sync_meas),
        .v_total_meas(v_total_meas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // frame_done snapshot
    int          fd_cnt = 0;
    logic [15:0] cap_crc;
    logic        cap_locked;
    logic        cap_err;
    logic [9:0]  cap_htot;
    logic [6:0]  cap_hsync;
    logic [9:0]  cap_vtot;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt     = fd_cnt + 1;
            cap_crc    = crc;
            cap_locked = locked;
            cap_err    = err;
            cap_htot   = h_total_meas;
            cap_hsync  = h_sync_meas;
            cap_vtot   = v_total_meas;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_flags"}, int'({locked, frame_done, err}), 0);
        check({tag, "_crc"}, int'(crc), 0);
        check({tag, "_meas"}, int'({h_total_meas, h_sync_meas, v_total_meas}), 0);
    endtask

    // Reference CRC-16/CCITT-FALSE bit update, symbol MSB first
    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [5:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 5; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [7:0] pins(input logic [5:0] sym, input logic hs, input logic vs);
        return {hs, sym[0], sym[2], sym[4], vs, sym[1], sym[3], sym[5]};
    endfunction

    task automatic put(input logic [7:0] v, input logic c);
        @(negedge clk);
        vga_in  = v;
        err_clr = c;
    endtask

    // One raster line. The DUT's hcount equals p-1 while position p is in its
    // input register, so visible positions are p in [HVO+1, HVO+HV].
    task automatic send_line(input int pat, input int flip, input int line, input int len,
                             input int clr, input logic [15:0] cin, output logic [15:0] cout);
        logic [15:0] c;
        logic [5:0]  sym;
        logic        vs;
        c = cin;
        for (int p = 0; p < len; p++) begin
            sym = (pat != 0) ? 6'((line * 7 + p * 3) % 64) : 6'd0;
            if (flip != 0 && line == VVO && p == HVO + 1) sym = sym ^ 6'h20;
            vs = !((line == 0 && p >= VS_POS) || (line == 1 && p < VS_POS));
            if (line >= VVO && line < VVO + VV && p >= HVO + 1 && p < HVO + 1 + HV)
                c = crc_model(c, sym);
            put(pins(sym, p >= HS, vs), (clr != 0 && line == 3 && p == 5));
        end
        cout = c;
    endtask

    task automatic send_frame(input int pat, input int flip, input int stretch, input int clr,
                              output logic [15:0] mcrc);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int l = 0; l < VT; l++)
            send_line(pat, flip, l, (l == VT - 1 && stretch != 0) ? HT + 1 : HT, clr, c, c);
        mcrc = c;
    endtask

    // Stimulus for frame i, and the expected verdict at frame i's leading vsync fall
    typedef struct {
        int pat;      // 0 black, 1 gradient
        int flip;     // invert first visible pixel
        int stretch;  // last line one clock long
        int clr;      // pulse err_clr during this frame
        int exp_fd;
        int exp_lk;
        int exp_err;
        int exp_htot;
        int cmp;      // 0 none, 1 crc equal to previous, 2 crc differs
    } row_t;

    row_t        rows[11];
    logic [15:0] mcrc;
    logic [15:0] prev_mcrc;
    logic [15:0] prev_cap;

    initial begin
        rows[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0};
        rows[1]  = '{1, 0, 0, 0, 1, 0, 0, 40, 0};
        rows[2]  = '{1, 0, 0, 0, 1, 1, 0, 40, 0};
        rows[3]  = '{1, 1, 0, 0, 1, 1, 0, 40, 1};
        rows[4]  = '{0, 0, 0, 0, 1, 1, 0, 40, 2};
        rows[5]  = '{0, 0, 1, 0, 1, 1, 0, 40, 2};
        rows[6]  = '{1, 0, 0, 0, 1, 0, 1, 41, 1};
        rows[7]  = '{1, 0, 0, 0, 1, 0, 1, 40, 0};
        rows[8]  = '{1, 0, 0, 0, 1, 1, 1, 40, 1};
        rows[9]  = '{1, 0, 0, 1, 1, 1, 1, 40, 1};
        rows[10] = '{1, 0, 0, 0, 1, 1, 0, 40, 1};

        rst_n   = 1'b0;
        ena     = 1'b1;
        err_clr = 1'b0;
        vga_in  = 8'hFF;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (4) put(8'hFF, 1'b0);

        prev_mcrc = 16'h0;
        prev_cap  = 16'h0;
        for (int i = 0; i < 11; i++) begin
            fd_cnt = 0;
            send_frame(rows[i].pat, rows[i].flip, rows[i].stretch, rows[i].clr, mcrc);
            check($sformatf("row%0d_frame_done", i), fd_cnt, rows[i].exp_fd);
            if (rows[i].exp_fd != 0) begin
                check($sformatf("row%0d_locked", i), int'(cap_locked), rows[i].exp_lk);
                check($sformatf("row%0d_err", i), int'(cap_err), rows[i].exp_err);
                check($sformatf("row%0d_h_total", i), int'(cap_htot), rows[i].exp_htot);
                check($sformatf("row%0d_h_sync", i), int'(cap_hsync), HS);
                check($sformatf("row%0d_v_total", i), int'(cap_vtot), VT);
                check($sformatf("row%0d_crc_model", i), int'(cap_crc), int'(prev_mcrc));
                if (rows[i].cmp == 1)
                    check($sformatf("row%0d_crc_repeat", i), int'(cap_crc), int'(prev_cap));
                if (rows[i].cmp == 2)
                    check($sformatf("row%0d_crc_changed", i), int'(cap_crc != prev_cap), 1);
                prev_cap = cap_crc;
            end else begin
                check($sformatf("row%0d_locked_live", i), int'(locked), rows[i].exp_lk);
            end
            prev_mcrc = mcrc;
        end

        // Watchdog: hsync stays high after the last line's falling edge (position 0)
        for (int j = HT; j <= 1025; j++) put(8'h88, 1'b0);
        check("wd_still_locked", int'({locked, err}), 2);
        put(8'h88, 1'b0);
        check("wd_locked_drop", int'(locked), 0);
        check("wd_err_set", int'(err), 1);

        fd_cnt = 0;
        send_frame(1, 0, 0, 0, mcrc);
        check("wd_no_frame_done", fd_cnt, 0);
        fd_cnt = 0;
        send_frame(1, 0, 0, 0, mcrc);
        check("wd_reacq_frame_done", fd_cnt, 1);
        check("wd_reacq_locked", int'(cap_locked), 0);
        fd_cnt = 0;
        send_frame(1, 0, 0, 0, mcrc);
        check("wd_relock", int'(cap_locked), 1);
        check("wd_err_sticky", int'(cap_err), 1);

        // Asynchronous reset in the middle of a frame
        mcrc = 16'hFFFF;
        for (int l = 0; l < 6; l++) send_line(1, 0, l, HT, 0, mcrc, mcrc);
        check("pre_rst_state", int'({locked, err}), 3);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("async_rst");
        repeat (3) put(8'h88, 1'b0);
        rst_n = 1'b1;
        put(8'h88, 1'b0);
        fd_cnt = 0;
        send_frame(1, 0, 0, 0, mcrc);
        check("post_rst_no_frame_done", fd_cnt, 0);
        fd_cnt = 0;
        send_frame(1, 0, 0, 0, mcrc);
        check("post_rst_frame_done", fd_cnt, 1);
        check("post_rst_locked", int'(cap_locked), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

Receive-side checker for the 640x480@60 VGA pattern generator. It samples the generator's 8-bit output pinout on the same clock and measures horizontal and vertical timing. A lock state machine reports sync health, and a per-frame CRC-16 over visible RGB pixels gives a frame signature. Used in loopback benches and as an on-chip self-test companion.

## Interface
- H_TOTAL_EXP, 800: expected clocks between hsync falling edges
- H_SYNC_EXP, 96: expected hsync low width (clocks)
- V_TOTAL_EXP, 525: expected hsync falls between vsync falls
- H_VIS_OFS, 143: first visible hcount
- H_VISIBLE, 640: visible pixels per line
- V_VIS_OFS, 35: first visible vline
- V_VISIBLE, 480: visible lines per frame
- LOCK_FRAMES, 2: consecutive good frames needed for lock (1..7)
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  low: synchronous clear of all state to reset values
- vga_in  in  8  pinout: [0]R1 [1]G1 [2]B1 [3]vsync_n [4]R0 [5]G0 [6]B0 [7]hsync_n
- err_clr  in  1  synchronous clear of err
- locked  out  1  timing locked
- frame_done  out  1  one-cycle pulse when crc/v_total_meas update
- err  out  1  sticky: lock lost
- crc  out  16  CRC of last complete frame
- h_total_meas  out  10  last measured line period
- h_sync_meas  out  7  last measured hsync width, saturating at 127
- v_total_meas  out  10  last measured line count per frame

## Operation
- Input register: s <= vga_in each cycle. s_d <= s. Edges use s and s_d: hs_fall = s_d[7]&~s[7], vs_fall likewise on bit 3, hs_rise = ~s_d[7]&s[7].
- hcount (10b): increments each cycle and saturates at 1023. On hs_fall: h_total_meas <= hcount+1, hcount <= 0.
- hlow (7b): increments while s[7]==0, saturating at 127. On hs_rise: h_sync_meas <= hlow, hlow <= 0.
- vlines (10b): increments on hs_fall. On vs_fall: v_total_meas <= vlines, vlines <= 0. If hs_fall and vs_fall coincide, vlines <= 1.
- Per-frame flag bad: set on any hs_fall with hcount+1 != H_TOTAL_EXP, and on any hs_rise with hlow != H_SYNC_EXP. At a vs_fall, the frame is bad if bad==1 or vlines != V_TOTAL_EXP. bad clears on vs_fall.
- Pixel: visible when H_VIS_OFS <= hcount < H_VIS_OFS+H_VISIBLE and V_VIS_OFS <= vlines < V_VIS_OFS+V_VISIBLE. Symbol = {R1,R0,G1,G0,B1,B0} from s, MSB first.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no xorout. 6 bits are shifted per visible cycle as a combinational 6-step update.
- On vs_fall the running CRC is re-initialised to 0xFFFF. If the state was not IDLE, crc <= running CRC and frame_done pulses.
- FSM states:
  - IDLE: wait for the first vs_fall, then go to ACQ with good_cnt=0. No frame_done is produced on this transition.
  - ACQ: on each vs_fall, a good frame increments good_cnt and a bad frame sets it to 0. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: a bad frame goes to ACQ with good_cnt=0 and sets err.
  - Watchdog (any state): hcount==1023 forces IDLE. If the state was LOCKED, err is also set.
- locked = (state==LOCKED).
- If err_clr and an err set event occur in the same cycle, set wins.

## Timing
- Reset / ena low values: all outputs 0. hcount, hlow, vlines, good_cnt = 0. s and s_d = 8'hFF (syncs idle high). Running CRC = 0xFFFF. State IDLE.
- Latency: a pin change reaches s after 1 cycle. The edge is detected in the following cycle, and measurement registers update 1 cycle after that.
- frame_done is high for exactly one cycle, the same cycle in which crc, v_total_meas and the FSM state update.
- Reset or ena low mid-frame drops lock immediately. No partial CRC is published.

## Test plan
- Generator loopback (mode 0, animate=0): h_total_meas=800, h_sync_meas=96, v_total_meas=525. locked rises on the cycle of the 3rd vs_fall. err=0.
- Same frame twice: the two frame_done pulses carry equal crc. All-black RGB frame crc equals the bench CRC-16/CCITT model over 307200 zero symbols.
- Flip one visible pixel (line 0, pixel 0) in frame N: crc differs from frame N-1. locked stays 1.
- While locked, stretch one line to 801 clocks: the next vs_fall drops locked, err=1, h_total_meas=801. Relock after 2 clean frames. err stays 1 until err_clr.
- While locked, hold hsync_n high: 1024 cycles after the last hs_fall, locked=0 and err=1. The next vs_fall produces no frame_done.
- Assert rst_n low mid-frame: all outputs 0 asynchronously. The first vs_fall after release produces no frame_done.
